// File: rtl/rf_pkg.sv
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared constants and types for the register-file write
//                arbiter (special register indices, write record type).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    // Register indices with special meaning in the register file
    localparam logic [4:0] REG_ZE = 5'd0;   // hard-wired zero
    localparam logic [4:0] REG_SE = 5'd1;   // sign/extension register
    localparam logic [4:0] REG_LO = 5'd17;  // mult/div low result
    localparam logic [4:0] REG_HI = 5'd18;  // mult/div high result

    // One write transaction as seen by the register file
    typedef struct packed {
        logic [4:0]  dr;
        logic [31:0] d;
        logic [31:0] d2;
    } rf_wr_t;

endpackage : rf_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first valid
//                requester at or after ptr_i, scanning upward with wrap.
//                Output is one-hot, or all-zero when disabled / nothing valid.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PW-1:0]      ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    logic          w_found;

    // Scan from the pointer upward (mod NUM_REQ); first valid index wins
    always_comb begin
        grant_o = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, ptr_i} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PW+1)'(NUM_REQ);
            end
            w_idx = w_sum[PW-1:0];
            if (en_i && !w_found && valid_i[w_idx]) begin
                grant_o[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/rf_write_arbiter.sv
// ============================================================================
//  Module      : rf_write_arbiter
//  Description : Shares the register file's single write port among NUM_REQ
//                producers using round-robin valid/ready arbitration and a
//                single registered output stage. Counts accepted writes.
//                Optional feature macro: RF_ARB_BYPASS_EN - forwards the
//                write currently on the port to the SR1/SR2 read outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DW      = 32,
    parameter int AW      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*AW-1:0] req_dr,
    input  logic [NUM_REQ*DW-1:0] req_data,
    input  logic [NUM_REQ*DW-1:0] req_data2,
    output logic                  rf_ld_reg,
    output logic [AW-1:0]         rf_dr,
    output logic [DW-1:0]         rf_data_in,
    output logic [DW-1:0]         rf_data_in2,
    input  logic [AW-1:0]         rd_sr1,
    input  logic [AW-1:0]         rd_sr2,
    input  logic [DW-1:0]         rf_sr1_out,
    input  logic [DW-1:0]         rf_sr2_out,
    output logic [DW-1:0]         byp_sr1_out,
    output logic [DW-1:0]         byp_sr2_out,
    output logic [15:0]           wr_count
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      ptr_q,   ptr_d;
    logic               ld_q;
    logic [AW-1:0]      dr_q;
    logic [DW-1:0]      data_q,  data2_q;
    logic [15:0]        count_q, count_d;

    logic [NUM_REQ-1:0] w_grant;
    logic               w_accept;
    logic [PW-1:0]      w_gidx;

    // Reset also blocks grants so nothing is accepted while it is held
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_arbiter (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (~stall & ~reset),
        .grant_o (w_grant)
    );

    assign req_ready = w_grant;
    assign w_accept  = |(w_grant & req_valid);

    // One-hot grant to index; next pointer sits just past the winner
    always_comb begin
        w_gidx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_gidx = PW'(k);
            end
        end
        ptr_d   = (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + PW'(1);
        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
    end

    // Pointer, output stage and write counter
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q   <= '0;
            ld_q    <= 1'b0;
            dr_q    <= '0;
            data_q  <= '0;
            data2_q <= '0;
            count_q <= '0;
        end else begin
            ld_q <= w_accept;
            if (w_accept) begin
                ptr_q   <= ptr_d;
                dr_q    <= req_dr   [w_gidx*AW +: AW];
                data_q  <= req_data [w_gidx*DW +: DW];
                data2_q <= req_data2[w_gidx*DW +: DW];
                count_q <= count_d;
            end
        end
    end

    assign rf_ld_reg   = ld_q;
    assign rf_dr       = dr_q;
    assign rf_data_in  = data_q;
    assign rf_data_in2 = data2_q;
    assign wr_count    = count_q;

`ifdef RF_ARB_BYPASS_EN
    localparam logic [AW-1:0] C_REG_ZE = AW'(REG_ZE);
    localparam logic [AW-1:0] C_REG_SE = AW'(REG_SE);
    localparam logic [AW-1:0] C_REG_LO = AW'(REG_LO);
    localparam logic [AW-1:0] C_REG_HI = AW'(REG_HI);

    // LO/HI are rewritten by every pulse; ZE/SE/LO/HI as DR never forward
    function automatic logic [DW-1:0] f_byp(
        input logic [AW-1:0] sr,
        input logic [DW-1:0] raw,
        input logic          ld,
        input logic [AW-1:0] dr,
        input logic [DW-1:0] d,
        input logic [DW-1:0] d2
    );
        logic special;
        special = (dr == C_REG_ZE) || (dr == C_REG_SE) ||
                  (dr == C_REG_LO) || (dr == C_REG_HI);
        if (!ld)                       return raw;
        else if (sr == C_REG_LO)       return d;
        else if (sr == C_REG_HI)       return d2;
        else if (sr == dr && !special) return d;
        else                           return raw;
    endfunction

    // Forward the in-flight write to both read ports
    always_comb begin
        byp_sr1_out = f_byp(rd_sr1, rf_sr1_out, ld_q, dr_q, data_q, data2_q);
        byp_sr2_out = f_byp(rd_sr2, rf_sr2_out, ld_q, dr_q, data_q, data2_q);
    end
`else
    logic w_unused_sr;

    // Without forwarding the read values pass straight through
    always_comb begin
        byp_sr1_out = rf_sr1_out;
        byp_sr2_out = rf_sr2_out;
        w_unused_sr = ^{rd_sr1, rd_sr2};
    end
`endif

endmodule : rf_write_arbiter

`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
// ============================================================================
//  Module      : tb_rf_write_arbiter
//  Description : Self-checking bench for rf_write_arbiter: directed scenarios
//                followed by random traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_write_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_dr;
    logic [N*DW-1:0] req_data;
    logic [N*DW-1:0] req_data2;
    logic            rf_ld_reg;
    logic [AW-1:0]   rf_dr;
    logic [DW-1:0]   rf_data_in;
    logic [DW-1:0]   rf_data_in2;
    logic [AW-1:0]   rd_sr1;
    logic [AW-1:0]   rd_sr2;
    logic [DW-1:0]   rf_sr1_out;
    logic [DW-1:0]   rf_sr2_out;
    logic [DW-1:0]   byp_sr1_out;
    logic [DW-1:0]   byp_sr2_out;
    logic [15:0]     wr_count;

    always #5 clk = ~clk;

    rf_write_arbiter #(
        .NUM_REQ (N),
        .DW      (DW),
        .AW      (AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dr      (req_dr),
        .req_data    (req_data),
        .req_data2   (req_data2),
        .rf_ld_reg   (rf_ld_reg),
        .rf_dr       (rf_dr),
        .rf_data_in  (rf_data_in),
        .rf_data_in2 (rf_data_in2),
        .rd_sr1      (rd_sr1),
        .rd_sr2      (rd_sr2),
        .rf_sr1_out  (rf_sr1_out),
        .rf_sr2_out  (rf_sr2_out),
        .byp_sr1_out (byp_sr1_out),
        .byp_sr2_out (byp_sr2_out),
        .wr_count    (wr_count)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit            m_known = 1'b0;
    int            m_ptr   = 0;
    logic          m_ld;
    logic [AW-1:0] m_dr;
    logic [DW-1:0] m_d, m_d2;
    int            m_count = 0;
    logic [N-1:0]  last_ready;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] g;
        int idx;
        g = '0;
        if (reset || stall) return g;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (req_valid[idx]) begin
                g[idx] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic logic [DW-1:0] exp_byp(input logic [AW-1:0] sr, input logic [DW-1:0] raw);
        if (!m_ld) return raw;
`ifdef RF_ARB_BYPASS_EN
        if (sr == 5'd17) return m_d;
        if (sr == 5'd18) return m_d2;
        if (sr == m_dr && !(m_dr inside {5'd0, 5'd1, 5'd17, 5'd18})) return m_d;
`endif
        return raw;
    endfunction

    // One clock cycle: check at the falling edge, advance the model at the rising edge
    task automatic step();
        logic [N-1:0] eg;
        int gi;
        @(negedge clk);
        eg = exp_grant();
        last_ready = req_ready;
        chk("ready", 32'(req_ready), 32'(eg));
        if (m_known) begin
            chk("ld_reg",  32'(rf_ld_reg),   32'(m_ld));
            chk("dr",      32'(rf_dr),       32'(m_dr));
            chk("data",    rf_data_in,       m_d);
            chk("data2",   rf_data_in2,      m_d2);
            chk("count",   32'(wr_count),    32'(m_count));
            chk("byp_sr1", byp_sr1_out,      exp_byp(rd_sr1, rf_sr1_out));
            chk("byp_sr2", byp_sr2_out,      exp_byp(rd_sr2, rf_sr2_out));
        end
        @(posedge clk);
        if (reset) begin
            m_known = 1'b1;
            m_ptr   = 0;
            m_ld    = 1'b0;
            m_dr    = '0;
            m_d     = '0;
            m_d2    = '0;
            m_count = 0;
        end else if (eg != '0) begin
            gi = 0;
            for (int k = 0; k < N; k++) if (eg[k]) gi = k;
            m_ld    = 1'b1;
            m_dr    = req_dr[gi*AW +: AW];
            m_d     = req_data[gi*DW +: DW];
            m_d2    = req_data2[gi*DW +: DW];
            m_ptr   = (gi + 1) % N;
            if (m_count < 65535) m_count++;
        end else begin
            m_ld = 1'b0;
        end
        #1;
    endtask

    logic [N-1:0] grants [6];
    logic [DW-1:0] raw1;

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        req_valid  = '0;
        req_dr     = '0;
        req_data   = '0;
        req_data2  = '0;
        rd_sr1     = '0;
        rd_sr2     = '0;
        rf_sr1_out = 32'h1111_1111;
        rf_sr2_out = 32'h2222_2222;

        // 1: reset held with all requesters valid
        req_valid = '1;
        step();
        step();
        chk("t1_ready", 32'(last_ready), 32'd0);
        chk("t1_ld",    32'(rf_ld_reg),  32'd0);
        chk("t1_count", 32'(wr_count),   32'd0);
        reset     = 1'b0;
        req_valid = '0;
        step();

        // 2: single requester 1
        req_valid              = 3'b010;
        req_dr[1*AW +: AW]     = 5'd5;
        req_data[1*DW +: DW]   = 32'hA5A5_0001;
        req_data2[1*DW +: DW]  = 32'h0000_0077;
        step();
        chk("t2_ready", 32'(last_ready), 32'b010);
        chk("t2_ld",    32'(rf_ld_reg),  32'd1);
        chk("t2_dr",    32'(rf_dr),      32'd5);
        chk("t2_data",  rf_data_in,      32'hA5A5_0001);
        req_valid = '0;
        step();

        // 3: all valid for six cycles from a fresh pointer
        reset = 1'b1;
        step();
        reset     = 1'b0;
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            req_dr   = {5'd3, 5'd2, 5'd4} + 15'(i);
            req_data = {32'(i), 32'(i + 100), 32'(i + 200)};
            step();
            grants[i] = last_ready;
            chk("t3_ld", 32'(rf_ld_reg), 32'd1);
        end
        for (int i = 0; i < 6; i++) chk("t3_grant", 32'(grants[i]), 32'(1 << (i % 3)));
        req_valid = '0;
        chk("t3_count", 32'(wr_count), 32'd6);
        step();

        // 4: stall blocks grants, then requester 0 wins when it drops
        stall     = 1'b1;
        req_valid = 3'b001;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_ready", 32'(last_ready), 32'd0);
            chk("t4_ld",    32'(rf_ld_reg),  32'd0);
        end
        chk("t4_count", 32'(wr_count), 32'd6);
        stall = 1'b0;
        step();
        chk("t4_grant", 32'(last_ready), 32'b001);
        req_valid = '0;
        step();

        // 5: forwarding of the write on the port
        req_valid             = 3'b001;
        req_dr[0 +: AW]       = 5'd14;
        req_data[0 +: DW]     = 32'hDEAD_BEEF;
        req_data2[0 +: DW]    = 32'h0000_1234;
        step();
        req_valid  = '0;
        raw1       = $urandom;
        rf_sr1_out = raw1;
        rd_sr1     = 5'd14;
        rd_sr2     = 5'd18;
        #1;
`ifdef RF_ARB_BYPASS_EN
        chk("t5_sr1_dr", byp_sr1_out, 32'hDEAD_BEEF);
        chk("t5_sr2_hi", byp_sr2_out, 32'h0000_1234);
`else
        chk("t5_sr1_dr", byp_sr1_out, raw1);
        chk("t5_sr2_hi", byp_sr2_out, rf_sr2_out);
`endif
        rd_sr1 = 5'd0;
        #1;
        chk("t5_sr1_ze", byp_sr1_out, raw1);
        step();

        // 6: reset right after an accept
        req_valid = 3'b010;
        step();
        reset     = 1'b1;
        req_valid = '0;
        step();
        reset = 1'b0;
        chk("t6_ld", 32'(rf_ld_reg), 32'd0);
        req_valid = 3'b101;
        step();
        chk("t6_grant", 32'(last_ready), 32'b001);
        req_valid = '0;
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            req_valid  = N'($urandom);
            req_dr     = (N*AW)'($urandom);
            req_data   = {$urandom, $urandom, $urandom};
            req_data2  = {$urandom, $urandom, $urandom};
            rf_sr1_out = $urandom;
            rf_sr2_out = $urandom;
            case ($urandom_range(0, 3))
                0:       rd_sr1 = m_dr;
                1:       rd_sr1 = 5'd17;
                2:       rd_sr1 = 5'd18;
                default: rd_sr1 = AW'($urandom);
            endcase
            rd_sr2 = ($urandom_range(0, 1) == 0) ? m_dr : AW'($urandom);
            step();
        end

        // Counter saturation
        reset = 1'b1;
        stall = 1'b0;
        step();
        reset     = 1'b0;
        req_valid = '1;
        repeat (65540) step();
        chk("sat_count", 32'(wr_count), 32'h0000_FFFF);
        req_valid = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rf_write_arbiter

`default_nettype wire
